// File: rtl/bloom_sram_shifter_pkg.sv
// ---------------------------------------------------------------------------
// bloom_sram_shifter_pkg
// Shared definitions for the Bloom-filter decay sweeper: sweep FSM state
// encoding, default parameter values and the lane-count helper.
// ---------------------------------------------------------------------------
package bloom_sram_shifter_pkg;

   localparam int unsigned DEF_SRAM_ADDR_WIDTH = 19;
   localparam int unsigned DEF_SRAM_DATA_WIDTH = 36;
   localparam int unsigned DEF_LANE_WIDTH      = 9;
   localparam int unsigned DEF_SHIFT_AMT       = 1;
   localparam int unsigned DEF_VLD_TIMEOUT     = 16;

   localparam int unsigned LANE_COUNT = DEF_SRAM_DATA_WIDTH / DEF_LANE_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_NEXT    = 3'd4
   } state_t;

   function automatic int unsigned lane_count(int unsigned dw, int unsigned lw);
      return dw / lw;
   endfunction

endpackage

// File: rtl/bloom_sram_shifter_if.sv
// ---------------------------------------------------------------------------
// bloom_sram_shifter_if
// Read/write request port pair between the sweeper (master) and the SRAM
// arbiter (slave).
//   rd_req/rd_addr   : read request and word address        (master -> slave)
//   rd_ack           : read request accepted                (slave -> master)
//   rd_vld/rd_data   : read data qualifier and data         (slave -> master)
//   wr_req/wr_addr/wr_data : write request, address, data   (master -> slave)
//   wr_ack           : write request accepted               (slave -> master)
// ---------------------------------------------------------------------------
interface bloom_sram_shifter_if #(
   parameter int unsigned AW = 19,
   parameter int unsigned DW = 36
);
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ack;
   logic          rd_vld;
   logic [DW-1:0] rd_data;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  rd_ack, rd_vld, rd_data, wr_ack
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output rd_ack, rd_vld, rd_data, wr_ack
   );
endinterface

// File: rtl/bloom_sram_shifter_lane_shift.sv
// ---------------------------------------------------------------------------
// bloom_lane_shift
// Purely combinational word shifter: every LANE_WIDTH-bit lane is shifted
// right by SHIFT_AMT independently, zero-filled, with no bits crossing into
// the neighbouring lane.
//   i_word : input word  (LANE_WIDTH*LANE_COUNT bits)
//   o_word : shifted word
// ---------------------------------------------------------------------------
module bloom_lane_shift #(
   parameter int unsigned LANE_WIDTH = 9,
   parameter int unsigned LANE_COUNT = 4,
   parameter int unsigned SHIFT_AMT  = 1
) (
   input  logic [LANE_WIDTH*LANE_COUNT-1:0] i_word,
   output logic [LANE_WIDTH*LANE_COUNT-1:0] o_word
);

   for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
      // A shift by the full lane width yields zero, which clears the table.
      assign o_word[g*LANE_WIDTH +: LANE_WIDTH] = i_word[g*LANE_WIDTH +: LANE_WIDTH] >> SHIFT_AMT;
   end

endmodule

// File: rtl/bloom_sram_shifter.sv
// ---------------------------------------------------------------------------
// bloom_sram_shifter
// Ages a Bloom-filter table in SRAM: sweeps num_words words starting at
// base_addr, reads each word, right-shifts every counter lane and writes the
// word back through the arbiter's second port pair.
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : arbiter initialised; start ignored while low
//   start             : one-cycle sweep start pulse
//   base_addr         : first word address (sampled on accepted start)
//   num_words         : word count (sampled on accepted start)
//   busy              : sweep in progress
//   done              : one-cycle pulse when the sweep ends
//   timeout_err       : one-cycle pulse per abandoned read
//   sram              : read/write request ports (master side)
//   words_shifted     : saturating count of words written back
//                       (only with BLOOM_SHIFTER_STATS_EN defined)
// ---------------------------------------------------------------------------
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for an accepted start
// S_RD_REQ  | read request held until rd_ack
// S_RD_WAIT | waiting for rd_vld, bounded by VLD_TIMEOUT
// S_WR_REQ  | write-back request held until wr_ack
// S_NEXT    | advance address, count down, finish or fetch next word
// ---------------------------------------------------------------------------
module bloom_sram_shifter
   import bloom_sram_shifter_pkg::*;
#(
   parameter int unsigned SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
   parameter int unsigned SRAM_DATA_WIDTH = DEF_SRAM_DATA_WIDTH,
   parameter int unsigned LANE_WIDTH      = DEF_LANE_WIDTH,
   parameter int unsigned SHIFT_AMT       = DEF_SHIFT_AMT,
   parameter int unsigned VLD_TIMEOUT     = DEF_VLD_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       start,
   input  logic [SRAM_ADDR_WIDTH-1:0] base_addr,
   input  logic [SRAM_ADDR_WIDTH-1:0] num_words,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout_err,
`ifdef BLOOM_SHIFTER_STATS_EN
   output logic [31:0]                words_shifted,
`endif
   bloom_sram_shifter_if.master       sram
);

   localparam int unsigned LANE_CNT = lane_count(SRAM_DATA_WIDTH, LANE_WIDTH);
   localparam int unsigned CNT_W    = $clog2(VLD_TIMEOUT + 1);
   // Last RD_WAIT cycle before the read is abandoned; the counter is 0 on entry.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VLD_TIMEOUT - 1);

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [SRAM_ADDR_WIDTH-1:0]  r_cur_addr;
   logic [SRAM_ADDR_WIDTH-1:0]  r_remaining;
   logic [CNT_W-1:0]            r_wait_cnt;
   logic [SRAM_DATA_WIDTH-1:0]  r_wr_data;
   logic                        r_done;
   logic                        r_timeout_err;
   logic [SRAM_DATA_WIDTH-1:0]  w_shifted;
   logic                        w_accept;
   logic                        w_rd_req;
   logic                        w_wr_req;
   logic                        w_vld_take;
   logic                        w_wr_take;
   logic                        w_timeout_hit;
   logic                        w_last_word;

   bloom_lane_shift #(
      .LANE_WIDTH (LANE_WIDTH),
      .LANE_COUNT (LANE_CNT),
      .SHIFT_AMT  (SHIFT_AMT)
   ) u_lane_shift (
      .i_word (sram.rd_data),
      .o_word (w_shifted)
   );

   assign w_last_word = (r_remaining == SRAM_ADDR_WIDTH'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Requests drop combinationally in the ack cycle: the arbiter re-samples
   // req there, so a held request would earn a second grant.
   always_comb begin
      w_state_nxt   = r_state;
      w_accept      = 1'b0;
      w_rd_req      = 1'b0;
      w_wr_req      = 1'b0;
      w_vld_take    = 1'b0;
      w_wr_take     = 1'b0;
      w_timeout_hit = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && enable) begin
               w_accept = 1'b1;
               if (num_words != '0) begin
                  w_state_nxt = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            w_rd_req = ~sram.rd_ack;
            if (sram.rd_ack) begin
               w_state_nxt = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (sram.rd_vld) begin
               w_vld_take  = 1'b1;
               w_state_nxt = S_WR_REQ;
            end else if (r_wait_cnt == CNT_LAST) begin
               w_timeout_hit = 1'b1;
               w_state_nxt   = S_NEXT;
            end
         end
         S_WR_REQ: begin
            w_wr_req = ~sram.wr_ack;
            if (sram.wr_ack) begin
               w_wr_take   = 1'b1;
               w_state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            w_state_nxt = w_last_word ? S_IDLE : S_RD_REQ;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cur_addr    <= '0;
         r_remaining   <= '0;
         r_wait_cnt    <= '0;
         r_wr_data     <= '0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_done        <= 1'b0;
         r_timeout_err <= w_timeout_hit;
         if (w_accept) begin
            r_cur_addr  <= base_addr;
            r_remaining <= num_words;
            r_done      <= (num_words == '0);
         end
         if (r_state == S_NEXT) begin
            r_cur_addr  <= r_cur_addr + SRAM_ADDR_WIDTH'(1);
            r_remaining <= r_remaining - SRAM_ADDR_WIDTH'(1);
            r_done      <= w_last_word;
         end
         // Held at zero outside RD_WAIT so every read starts a fresh window.
         r_wait_cnt <= (r_state == S_RD_WAIT) ? r_wait_cnt + CNT_W'(1) : '0;
         if (w_vld_take) begin
            r_wr_data <= w_shifted;
         end
      end
   end

`ifdef BLOOM_SHIFTER_STATS_EN
   logic [31:0] r_words_shifted;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_words_shifted <= '0;
      end else if (w_accept) begin
         r_words_shifted <= '0;
      end else if (w_wr_take && (r_words_shifted != '1)) begin
         r_words_shifted <= r_words_shifted + 32'd1;
      end
   end

   assign words_shifted = r_words_shifted;
`endif

   assign busy         = (r_state != S_IDLE);
   assign done         = r_done;
   assign timeout_err  = r_timeout_err;
   assign sram.rd_req  = w_rd_req;
   assign sram.rd_addr = r_cur_addr;
   assign sram.wr_req  = w_wr_req;
   assign sram.wr_addr = r_cur_addr;
   assign sram.wr_data = r_wr_data;

endmodule
